pe_row_ctrl: RTL and testbench

PE_ROW_CTRL -- requirements
Module: pe_row_ctrl

---
 rtl/pe_row_ctrl.sv | 126 ++++++++++++
 tb/tb_pe_row_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_ctrl.sv
// Sequences weight reload and vector streaming into a PE row, and re-times its results onto out_valid/out_data.
// Latency: a vector accepted at edge t appears on out_valid/out_data at edge t+PIPE_LAT+2.
// Backpressure: in_ready is high only in STREAM; the output side has no backpressure.
module pe_row_ctrl #(
    parameter int DATA_BW        = 8,
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int PIPE_LAT       = 2,
    parameter int CNT_BW         = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            cfg_reload,
    input  logic [CNT_BW-1:0]               num_vec,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]  in_data,
    output logic                            pe_weight_reload,
    output logic [DATA_BW*MATRIX_SIZE-1:0]  pe_data_in,
    input  logic [PARTIAL_SUM_BW-1:0]       pe_data_out,
    output logic                            out_valid,
    output logic [PARTIAL_SUM_BW-1:0]       out_data,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RELOAD = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state;
    logic [CNT_BW-1:0]   len;
    logic [CNT_BW-1:0]   count;
    logic                pe_vld;
    logic [PIPE_LAT:0]   vld_sr;
    logic                accept;

    assign accept = in_valid & in_ready;

    // pe_vld marks that pe_data_in holds an accepted vector; the PE row samples it one
    // cycle later, so the valid shift register starts from pe_vld rather than accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            len              <= '0;
            count            <= '0;
            pe_vld           <= 1'b0;
            vld_sr           <= '0;
            pe_data_in       <= '0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            in_ready         <= 1'b0;
            pe_weight_reload <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            pe_data_in       <= accept ? in_data : '0;
            pe_vld           <= accept;
            vld_sr           <= {vld_sr[PIPE_LAT-1:0], pe_vld};
            out_valid        <= vld_sr[PIPE_LAT];
            out_data         <= pe_data_out;
            done             <= 1'b0;
            pe_weight_reload <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= num_vec;
                        count <= '0;
                        busy  <= 1'b1;
                        if (cfg_reload) begin
                            state            <= RELOAD;
                            pe_weight_reload <= 1'b1;
                        end else if (num_vec == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= STREAM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RELOAD: begin
                    if (len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= STREAM;
                        in_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        // len is at least 1 here, so len-1 cannot wrap
                        if (count == len - 1'b1) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!pe_vld && vld_sr == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_row_ctrl.sv
// Bench for pe_row_ctrl: job table driven through a PE-row model, results checked by a scoreboard.
module tb_pe_row_ctrl;

    localparam int DW  = 8;
    localparam int MS  = 8;
    localparam int PSB = 20;
    localparam int P   = 2;
    localparam int CB  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cfg_reload = 1'b0;
    logic [CB-1:0]     num_vec = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW*MS-1:0]  in_data = '0;
    logic              pe_weight_reload;
    logic [DW*MS-1:0]  pe_data_in;
    logic [PSB-1:0]    pe_data_out;
    logic              out_valid;
    logic [PSB-1:0]    out_data;
    logic              busy;
    logic              done;

    pe_row_ctrl #(
        .DATA_BW(DW), .MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .PIPE_LAT(P), .CNT_BW(CB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_reload(cfg_reload), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pe_weight_reload(pe_weight_reload), .pe_data_in(pe_data_in),
        .pe_data_out(pe_data_out), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PSB-1:0] pe_f(input logic [DW*MS-1:0] v);
        logic [PSB-1:0] s;
        s = '0;
        for (int i = 0; i < MS; i++)
            s = s + {{(PSB-DW){v[i*DW+DW-1]}}, v[i*DW +: DW]};
        return s;
    endfunction

    // PE row model: samples pe_data_in one edge after it changes, then PIPE_LAT stages
    logic [PSB-1:0] pe_pipe [0:P];
    assign pe_data_out = pe_pipe[P];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i <= P; i++) pe_pipe[i] <= '0;
        end else begin
            pe_pipe[0] <= pe_f(pe_data_in);
            for (int i = 1; i <= P; i++) pe_pipe[i] <= pe_pipe[i-1];
        end
    end

    typedef struct {
        logic [PSB-1:0] d;
        int             c;
    } exp_t;
    exp_t sb[$];

    logic             mon_en = 1'b0;
    logic             acc_pend = 1'b0;
    logic [DW*MS-1:0] dat_pend = '0;
    int ov_cnt = 0, done_cnt = 0, reload_cnt = 0;
    int done_cyc = 0, reload_cyc = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("pe_data_in", pe_data_in, acc_pend ? dat_pend : '0);
            if (out_valid) begin
                ov_cnt++;
                chk("sb_nonempty", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_cycle", cyc, e.c);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pe_weight_reload) begin
                reload_cnt++;
                reload_cyc = cyc;
            end
            if (rst) begin
                sb.delete();
                acc_pend = 1'b0;
            end else begin
                acc_pend = in_valid & in_ready;
                dat_pend = in_data;
                if (acc_pend) sb.push_back('{pe_f(in_data), cyc + P + 3});
            end
        end
    end

    typedef struct {
        logic       rl;
        int         nv;
        logic [7:0] vpat;
        int         poke;
        int         rst_acc;
        int         exp_outs;
        int         exp_reloads;
        int         exp_done;
        int         done_lat;
    } job_t;

    int tot_ov = 0, tot_exp = 0;

    task automatic run_job(input job_t j);
        int k, accepts, budget, start_edge;
        logic done_seen, did_rst;
        ov_cnt = 0; done_cnt = 0; reload_cnt = 0;
        k = 0; accepts = 0; done_seen = 1'b0; did_rst = 1'b0;
        budget = 8 * j.nv + 40;
        start_edge = cyc + 1;
        while (!done_seen && !did_rst && k < budget) begin
            if (j.rst_acc >= 0 && k > 0 && accepts == j.rst_acc) begin
                rst = 1'b1; in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_done", done, 0);
                chk("rst_reload", pe_weight_reload, 0);
                chk("rst_pe_data_in", pe_data_in, 0);
                chk("rst_out_data", out_data, 0);
                repeat (2 * P + 8) @(posedge clk);
                #1;
                did_rst = 1'b1;
            end else begin
                start      = (k == 0) || (k == j.poke);
                num_vec    = (k == 0) ? CB'(j.nv) : CB'(9);
                cfg_reload = (k == 0) ? j.rl : 1'b1;
                in_valid   = j.vpat[k % 8];
                in_data    = {$urandom, $urandom};
                if (in_valid && in_ready) accepts++;
                @(posedge clk); #1;
                start = 1'b0;
                if (k == 0) chk("busy_after_start", busy, 1);
                done_seen = done;
                k++;
            end
        end
        in_valid = 1'b0;
        if (!did_rst) begin
            chk("done_seen", done_seen, 1);
            chk("accepts", accepts, j.nv);
            @(posedge clk); #1;
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
        end
        chk("out_valid_count", ov_cnt, j.exp_outs);
        chk("done_count", done_cnt, j.exp_done);
        chk("reload_count", reload_cnt, j.exp_reloads);
        if (j.rl) chk("reload_cycle", reload_cyc, start_edge);
        if (j.done_lat >= 0) chk("done_latency", done_cyc - start_edge, j.done_lat);
        tot_ov += ov_cnt;
        tot_exp += j.exp_outs;
    endtask

    job_t jobs [9];

    initial begin
        //             rl  nv   vpat   poke rst  outs rel done lat
        jobs[0] = '{1'b1, 4,   8'hFF, -1, -1, 4,   1,  1,  -1};
        jobs[1] = '{1'b0, 3,   8'h55, -1, -1, 3,   0,  1,  -1};
        jobs[2] = '{1'b0, 0,   8'hFF, -1, -1, 0,   0,  1,  0};
        jobs[3] = '{1'b1, 0,   8'hFF, -1, -1, 0,   1,  1,  1};
        jobs[4] = '{1'b0, 3,   8'hFF, 2,  -1, 3,   0,  1,  -1};
        jobs[5] = '{1'b0, 5,   8'hFF, -1, 2,  0,   0,  0,  -1};
        jobs[6] = '{1'b0, 6,   8'h1D, -1, -1, 6,   0,  1,  -1};
        jobs[7] = '{1'b1, 2,   8'hFF, -1, -1, 2,   1,  1,  -1};
        jobs[8] = '{1'b0, 255, 8'hFF, -1, -1, 255, 0,  1,  -1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_reload", pe_weight_reload, 0);
        chk("reset_pe_data_in", pe_data_in, 0);
        chk("reset_out_data", out_data, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_job(jobs[i]);

        repeat (P + 6) @(posedge clk);
        #1;
        chk("total_out_valid", tot_ov, tot_exp);
        chk("sb_empty_at_end", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
